// File: rtl/bool_bist_pkg.sv
// Shared types and constants for the 3-input Boolean block self-test engine.
// GOLDEN_Q1 is the truth table of F = AB + A'C, bit i = F for {A,B,C} = i.
package bool_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } bist_state_t;

    localparam logic [7:0]  GOLDEN_Q1 = 8'hCA;
    localparam int unsigned VEC_W     = 3;
    localparam int unsigned NUM_VEC   = 8;

endpackage

// File: rtl/bool_bist_settle_timer.sv
// Loadable 4-bit down-counter that holds each stimulus vector for the settle time.
// Load has priority over count; the counter parks at zero.
module bool_bist_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/bool3_bist_ctrl.sv
// BIST controller: sweeps all 8 {A,B,C} vectors into a combinational block, samples F
// after a settle time, and compares the captured truth table against GOLDEN.
module bool3_bist_ctrl
    import bool_bist_pkg::*;
#(
    parameter logic [7:0]  GOLDEN        = GOLDEN_Q1,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_f,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [3:0] fail_cnt,
    output logic [2:0] fail_idx
);

    localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NUM_VEC - 1);
    localparam logic [3:0]       TIMER_INIT = 4'(SETTLE_CYCLES - 1);

    bist_state_t      state;
    logic [VEC_W-1:0] vec;
    logic             accept;
    logic             mismatch;
    logic             timer_load;
    logic             timer_en;
    logic             timer_zero;

    assign accept     = ((state == IDLE) || (state == DONE)) && start;
    assign mismatch   = (dut_f != GOLDEN[vec]);
    assign timer_load = accept || ((state == SAMPLE) && (vec != LAST_VEC));
    assign timer_en   = (state == SETTLE);

    bool_bist_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (TIMER_INIT),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    // The vector register drives the stimulus directly, so it stays at 7 in DONE.
    assign dut_a = vec[2];
    assign dut_b = vec[1];
    assign dut_c = vec[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            vec      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            captured <= '0;
            fail_cnt <= '0;
            fail_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec      <= '0;
                        captured <= '0;
                        fail_cnt <= '0;
                        fail_idx <= '0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (timer_zero) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    captured[vec] <= dut_f;
                    if (mismatch) begin
                        fail_cnt <= fail_cnt + 4'd1;
                        if (fail_cnt == 4'd0) begin
                            fail_idx <= vec;
                        end
                    end
                    // pass folds in the current vector, since fail_cnt updates on this edge
                    if (vec == LAST_VEC) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_cnt == 4'd0) && !mismatch;
                        state <= DONE;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bool3_bist_ctrl.sv
// Directed self-checking bench for bool3_bist_ctrl with a behavioural 3-input block
// model selectable between correct, stuck-at-0 and AB + AC variants.
module tb_bool3_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start1;
    logic       dut_f, dut_f1;
    logic       dut_a, dut_b, dut_c, dut_a1, dut_b1, dut_c1;
    logic       busy, done, pass, busy1, done1, pass1;
    logic [7:0] captured, captured1;
    logic [3:0] fail_cnt, fail_cnt1;
    logic [2:0] fail_idx, fail_idx1;
    int         mode;
    int         checks = 0;
    int         errors = 0;
    int         cyc, bcnt;

    always #5 clk = ~clk;

    always_comb begin
        dut_f = 1'b0;
        case (mode)
            0: dut_f = (dut_a & dut_b) | (~dut_a & dut_c);
            1: dut_f = 1'b0;
            2: dut_f = (dut_a & dut_b) | (dut_a & dut_c);
            default: dut_f = 1'b0;
        endcase
    end

    assign dut_f1 = (dut_a1 & dut_b1) | (~dut_a1 & dut_c1);

    bool3_bist_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_f(dut_f),
        .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c),
        .busy(busy), .done(done), .pass(pass),
        .captured(captured), .fail_cnt(fail_cnt), .fail_idx(fail_idx)
    );

    bool3_bist_ctrl #(.GOLDEN(8'hCA), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_f(dut_f1),
        .dut_a(dut_a1), .dut_b(dut_b1), .dut_c(dut_c1),
        .busy(busy1), .done(done1), .pass(pass1),
        .captured(captured1), .fail_cnt(fail_cnt1), .fail_idx(fail_idx1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept a start on the next edge, then count edges until done rises (bounded).
    task automatic run_sweep(input bit pulse, output int n, output int b);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        b = busy ? 1 : 0;
        while (!done && n < 200) begin
            start = pulse && (n == 3 || n == 10);
            @(posedge clk); #1;
            n++;
            if (busy) b++;
        end
        start = 1'b0;
    endtask

    task automatic wait_done1(output int n);
        n = 0;
        while (!done1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {29'd0, dut_a, dut_b, dut_c}, 32'd0);
        check("reset_flags", {29'd0, busy, done, pass}, 32'd0);
        check("reset_results", {17'd0, captured, fail_cnt, fail_idx}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_no_start", {30'd0, busy, done}, 32'd0);

        // 1: correct block
        mode = 0;
        run_sweep(1'b0, cyc, bcnt);
        check("t1_latency", cyc, 24);
        check("t1_busy_cycles", bcnt, 24);
        check("t1_captured", captured, 8'hCA);
        check("t1_pass", pass, 1);
        check("t1_fail_cnt", fail_cnt, 0);
        check("t1_fail_idx", fail_idx, 0);
        check("t1_hold_vec7", {dut_a, dut_b, dut_c}, 3'b111);
        @(posedge clk); #1;
        check("t1_done_held", {done, busy, captured}, {1'b1, 1'b0, 8'hCA});

        // 2: stuck-at-0
        mode = 1;
        run_sweep(1'b0, cyc, bcnt);
        check("t2_latency", cyc, 24);
        check("t2_captured", captured, 8'h00);
        check("t2_pass", pass, 0);
        check("t2_fail_cnt", fail_cnt, 4);
        check("t2_fail_idx", fail_idx, 1);

        // 3: AB + AC mismatches at vectors 1, 3, 5
        mode = 2;
        run_sweep(1'b0, cyc, bcnt);
        check("t3_captured", captured, 8'hE0);
        check("t3_pass", pass, 0);
        check("t3_fail_cnt", fail_cnt, 3);
        check("t3_fail_idx", fail_idx, 1);

        // 4: start pulses mid-sweep ignored
        mode = 0;
        run_sweep(1'b1, cyc, bcnt);
        check("t4_latency", cyc, 24);
        check("t4_busy_cycles", bcnt, 24);
        check("t4_result", {pass, fail_cnt, captured}, {1'b1, 4'd0, 8'hCA});

        // 5: reset mid-sweep
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("t5_mid_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t5_abort_all",
              {dut_a, dut_b, dut_c, busy, done, pass, captured, fail_cnt, fail_idx}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t5_idle_after", {busy, done}, 0);
        mode = 0;
        run_sweep(1'b0, cyc, bcnt);
        check("t5_latency", cyc, 24);
        check("t5_result", {pass, fail_cnt, fail_idx, captured}, {1'b1, 4'd0, 3'd0, 8'hCA});

        // 6: SETTLE_CYCLES=1, start held high for free-running retest
        start1 = 1'b1;
        @(posedge clk); #1;
        check("t6_busy_on_accept", busy1, 1);
        wait_done1(cyc);
        check("t6_latency1", cyc, 16);
        check("t6_result1", {pass1, fail_cnt1, captured1}, {1'b1, 4'd0, 8'hCA});
        @(posedge clk); #1;
        check("t6_restart", {done1, busy1}, 2'b01);
        wait_done1(cyc);
        check("t6_latency2", cyc, 16);
        check("t6_result2", {pass1, fail_cnt1, fail_idx1, captured1},
              {1'b1, 4'd0, 3'd0, 8'hCA});
        start1 = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
